// File: rtl/nios_system_pio_pkg.sv
// Shared definitions for the Nios II system PIO blocks.
//   - Avalon-MM register addresses used by the PIO slaves.
//   - Edge-type encoding for edge-capturing input ports.
//   - pio_edge_detect(): per-bit edge detection on a 32-bit lane;
//     callers slice the result down to their own width.
package nios_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    function automatic logic [31:0] pio_edge_detect(
        input logic [31:0] cur,
        input logic [31:0] prev,
        input edge_type_e  kind
    );
        logic [31:0] evt;
        case (kind)
            EDGE_RISE: evt = cur & ~prev;
            EDGE_FALL: evt = ~cur & prev;
            default:   evt = cur ^ prev;
        endcase
        return evt;
    endfunction

endpackage

// File: rtl/nios_system_pio_debounce.sv
// One input line of a PIO input port: 2-flop synchroniser followed by an
// optional debounce filter (compiled in with SENSOR_PIO_DEBOUNCE_EN).
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   d_in       asynchronous external input
//   cond       conditioned (synchronised, optionally debounced) value
//   cond_valid high once cond carries a real sample of d_in after reset
module nios_system_pio_debounce
`ifdef SENSOR_PIO_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic reset_n,
    input  logic d_in,
    output logic cond,
    output logic cond_valid
);

    logic       sync1;
    logic       sync2;
    logic [1:0] vld;    // tracks the synchroniser filling after reset

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            vld   <= '0;
        end else begin
            sync1 <= d_in;
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
        end
    end

`ifdef SENSOR_PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             cond_q;
    logic             seeded;

    // The first valid synchronised sample is loaded straight into cond so
    // a level held through reset is not later seen as a debounced change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            cond_q <= 1'b0;
            seeded <= 1'b0;
        end else if (!seeded) begin
            cnt <= '0;
            if (vld[1]) begin
                cond_q <= sync2;
                seeded <= 1'b1;
            end
        end else if (sync2 == cond_q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cond_q <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign cond       = cond_q;
    assign cond_valid = seeded;
`else
    assign cond       = sync2;
    assign cond_valid = vld[1];
`endif

endmodule

// File: rtl/nios_system_sensor_pio_in.sv
// Avalon-MM slave input PIO for sensor status lines (data-ready, alert).
// Synchronises (and optionally debounces) in_port, records per-bit edge
// events in a sticky W1C capture register and raises a maskable level irq.
// Debounce is compiled in with `define SENSOR_PIO_DEBOUNCE_EN.
//   clk, reset_n  clock, asynchronous active-low reset
//   address       register select: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP
//   chipselect    slave select
//   write_n       active-low write strobe
//   writedata     write data
//   in_port       asynchronous external inputs (WIDTH bits)
//   readdata      combinational read data, upper bits zero
//   irq           registered level interrupt
module nios_system_sensor_pio_in
    import nios_system_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE > 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("nios_system_sensor_pio_in: illegal parameter set");
    end

    logic [WIDTH-1:0] cond;
    logic [WIDTH-1:0] cond_valid;
    logic [WIDTH-1:0] prev;
    logic             primed;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] clr;
    logic [31:0]      edge_full;
    logic             wr_en;
    logic             unused_bits;

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_line
`ifdef SENSOR_PIO_DEBOUNCE_EN
        if (gi == 0 && DEBOUNCE_CYCLES < 2) begin : g_bad_db
            $error("nios_system_sensor_pio_in: DEBOUNCE_CYCLES must be >= 2");
        end
        nios_system_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_line (
            .clk        (clk),
            .reset_n    (reset_n),
            .d_in       (in_port[gi]),
            .cond       (cond[gi]),
            .cond_valid (cond_valid[gi])
        );
`else
        nios_system_pio_debounce u_line (
            .clk        (clk),
            .reset_n    (reset_n),
            .d_in       (in_port[gi]),
            .cond       (cond[gi]),
            .cond_valid (cond_valid[gi])
        );
`endif
    end

    assign edge_full = pio_edge_detect(32'(cond), 32'(prev), edge_type_e'(2'(EDGE_TYPE)));
    assign edge_evt  = primed ? edge_full[WIDTH-1:0] : '0;

    assign wr_en = chipselect & ~write_n;
    assign clr   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    assign unused_bits = ^{writedata, edge_full};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev    <= '0;
            primed  <= 1'b0;
            irqmask <= '0;
            edgecap <= '0;
            irq     <= 1'b0;
        end else begin
            prev   <= cond;
            primed <= &cond_valid;
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // A new edge outranks a simultaneous W1C on the same bit.
            edgecap <= (edgecap & ~clr) | edge_evt;
            irq     <= |(edgecap & irqmask);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(cond);
            ADDR_IRQMASK: readdata = 32'(irqmask);
            ADDR_EDGECAP: readdata = 32'(edgecap);
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_system_sensor_pio_in.sv
// Directed self-checking bench for nios_system_sensor_pio_in (WIDTH=4,
// rising-edge capture). Works in both builds; the glitch-rejection case
// is only run when SENSOR_PIO_DEBOUNCE_EN is defined.
module tb_nios_system_sensor_pio_in;

`ifdef SENSOR_PIO_DEBOUNCE_EN
    localparam int unsigned LAT = 2 + 16;
`else
    localparam int unsigned LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    nios_system_sensor_pio_in #(
        .WIDTH           (4),
        .EDGE_TYPE       (0),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check_eq(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        cycle(3);

        // Reset state with inputs held high
        chk_reg("rst_data", 2'd0, 32'h0);
        chk_reg("rst_mask", 2'd2, 32'h0);
        chk_reg("rst_ecap", 2'd3, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);

        // Release: level held through reset must not be captured
        reset_n = 1'b1;
        cycle(10);
        chk_reg("prime_data", 2'd0, 32'hF);
        chk_reg("prime_ecap", 2'd3, 32'h0);
        check_eq("prime_irq", 32'(irq), 32'h0);

        // Falling edges ignored for rising-edge capture
        in_port = 4'h0;
        cycle(LAT + 2);
        chk_reg("fall_data", 2'd0, 32'h0);
        chk_reg("fall_ecap", 2'd3, 32'h0);

        // Rising edge on bit 0 with IRQMASK=1: pin -> DATA -> EDGECAP -> irq
        wr(2'd2, 32'h1);
        chk_reg("mask_rd", 2'd2, 32'h1);
        in_port = 4'b0001;
        cycle(LAT - 1);
        chk_reg("b0_data_early", 2'd0, 32'h0);
        cycle(1);
        chk_reg("b0_data", 2'd0, 32'h1);
        chk_reg("b0_ecap_early", 2'd3, 32'h0);
        cycle(1);
        chk_reg("b0_ecap", 2'd3, 32'h1);
        check_eq("b0_irq_early", 32'(irq), 32'h0);
        cycle(1);
        check_eq("b0_irq", 32'(irq), 32'h1);

        // W1C: flag clears on the write edge, irq one cycle later
        wr(2'd3, 32'h1);
        chk_reg("w1c_ecap", 2'd3, 32'h0);
        check_eq("w1c_irq_hold", 32'(irq), 32'h1);
        cycle(1);
        check_eq("w1c_irq_fall", 32'(irq), 32'h0);

        // Edge on bit 2 coincident with W1C of bit 2: set wins
        in_port = 4'b0101;
        cycle(LAT);
        wr(2'd3, 32'h4);
        chk_reg("setwins_ecap", 2'd3, 32'h4);
        cycle(1);
        check_eq("setwins_irq_masked", 32'(irq), 32'h0);
        wr(2'd3, 32'h4);
        chk_reg("setwins_clr", 2'd3, 32'h0);

        // Masked capture, then unmask
        wr(2'd2, 32'h0);
        in_port = 4'b0111;
        cycle(LAT + 2);
        chk_reg("masked_ecap", 2'd3, 32'h2);
        check_eq("masked_irq", 32'(irq), 32'h0);
        wr(2'd3, 32'h1);
        chk_reg("w1c_other_bit", 2'd3, 32'h2);
        wr(2'd2, 32'h2);
        check_eq("unmask_irq_early", 32'(irq), 32'h0);
        cycle(1);
        check_eq("unmask_irq", 32'(irq), 32'h1);
        chk_reg("unmask_mask_rd", 2'd2, 32'h2);

        // DATA and reserved address ignore writes
        wr(2'd0, 32'hFFFF_FFFF);
        chk_reg("data_ro", 2'd0, 32'h7);
        wr(2'd1, 32'hFFFF_FFFF);
        chk_reg("rsvd_rd", 2'd1, 32'h0);
        chk_reg("rsvd_mask_kept", 2'd2, 32'h2);

`ifdef SENSOR_PIO_DEBOUNCE_EN
        // 10-cycle glitch on bit 3 is filtered out
        in_port = 4'b1111;
        cycle(10);
        in_port = 4'b0111;
        cycle(LAT + 4);
        chk_reg("glitch_data", 2'd0, 32'h7);
        chk_reg("glitch_ecap", 2'd3, 32'h2);
`endif

        // Stable rise on bit 3: exact DATA latency and capture
        wr(2'd3, 32'hF);
        in_port = 4'b1111;
        cycle(LAT - 1);
        chk_reg("b3_data_early", 2'd0, 32'h7);
        cycle(1);
        chk_reg("b3_data", 2'd0, 32'hF);
        cycle(1);
        chk_reg("b3_ecap", 2'd3, 32'h8);

        // Build EDGECAP=0xF, start an input change, then reset mid-flight
        in_port = 4'h0;
        cycle(LAT + 2);
        wr(2'd3, 32'hF);
        in_port = 4'hF;
        cycle(LAT + 2);
        chk_reg("pre_rst_ecap", 2'd3, 32'hF);
        check_eq("pre_rst_irq", 32'(irq), 32'h1);
        in_port = 4'h0;
        cycle(5);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_irq", 32'(irq), 32'h0);
        chk_reg("midrst_data", 2'd0, 32'h0);
        chk_reg("midrst_mask", 2'd2, 32'h0);
        chk_reg("midrst_ecap", 2'd3, 32'h0);
        in_port = 4'hF;
        cycle(3);
        reset_n = 1'b1;
        cycle(10);
        chk_reg("rerel_data", 2'd0, 32'hF);
        chk_reg("rerel_ecap", 2'd3, 32'h0);
        check_eq("rerel_irq", 32'(irq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_system_sensor_pio_in.md
# nios_system_sensor_pio_in

Avalon-MM slave input port that reads sensor-side status lines, such as BME data-ready and alert pins, into the Nios II system. It sits on the same system interconnect as the output PIO blocks that drive sensor chip-selects. It synchronises asynchronous inputs and records per-bit edge events in a sticky capture register. It raises a maskable level interrupt to the CPU.

## Interface
- WIDTH, 4: number of input lines (1..32).
- EDGE_TYPE, 0: edge captured; 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 16: stable-cycle count required before a synchronised input is accepted; used only when debounce is compiled in (≥2).
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external input lines.
- readdata  output  32  read data, combinational from address; upper bits zero.
- irq  output  1  level interrupt to CPU.

## Operation
- Register map, all unused bits read 0:
  - addr 0 DATA (RO): conditioned input value. Writes are ignored.
  - addr 1: reserved; reads 0; writes are ignored.
  - addr 2 IRQMASK (RW, WIDTH bits).
  - addr 3 EDGECAP (R/W1C): sticky edge flags.
- Input path: in_port → 2-flop synchroniser → (optional debounce) → `cond`.
- Edge detect:
  - `prev` holds `cond` from the previous cycle.
  - Rising = cond & ~prev; falling = ~cond & prev; any = cond ^ prev.
- Priming after reset:
  - `primed` flag resets to 0 and sets after the first conditioned sample.
  - While `primed` = 0, edge detection is suppressed.
  - Effect: an input held high through reset does not produce a capture.
- EDGECAP bit update per cycle:
  - Next = (cur & ~clr) | edge.
  - clr = writedata[WIDTH-1:0] when chipselect & ~write_n & address==3.
  - Simultaneous edge and clear on the same bit: set wins.
- irq = |(EDGECAP & IRQMASK), registered. It is level-type and stays high until the CPU clears the flags or masks them.
- Writes to IRQMASK take effect the next cycle.
- Reset values: sync flops, `cond`, `prev`, `primed`, IRQMASK, EDGECAP, irq all 0; readdata combinational, so it is 0 only for addr 1 or when the selected register is 0.
- Reset mid-operation clears all state immediately. Debounce counters reset to 0.

## Timing
- Read latency: 0 wait states; readdata is combinational from address and register state. chipselect is not required to gate readdata.
- Input-to-DATA latency:
  - Without debounce: 2 cycles (synchroniser only).
  - With debounce: 2 + DEBOUNCE_CYCLES cycles from a stable change.
- Edge-to-EDGECAP: 1 cycle after `cond` changes.
- EDGECAP-to-irq: 1 cycle.
- Total pin edge to irq, no debounce: 4 cycles.
- W1C write: flag clears on the clock edge of the write; irq falls one cycle later.

## Configuration
- `SENSOR_PIO_DEBOUNCE_EN` defined:
  - Each bit gets a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets to 0 whenever the synchronised value equals `cond`.
  - Otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES-1, `cond` takes the synchronised value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach `cond`.
- Undefined: `cond` = synchroniser output directly; DEBOUNCE_CYCLES ignored; no counter logic.

## Structure
- Shared package `nios_system_pio_pkg`:
  - Register address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3).
  - EDGE_TYPE encoding constants (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- Sub-module `nios_system_pio_debounce`: one bit, synchroniser plus optional counter. Instantiated WIDTH times via generate.
- Top level holds the edge logic, registers, read mux and irq.

## Test plan
- Reset with in_port=4'b1111 held, release, wait 10 cycles → DATA=0xF, EDGECAP=0, irq=0.
- EDGE_TYPE=0, IRQMASK=0x1, pulse in_port[0] 0→1 (no debounce) → EDGECAP=0x1 by cycle 3, irq=1 at cycle 4. Write 0x1 to addr 3 → EDGECAP=0, irq=0 next cycle.
- Edge on bit 2 in the same cycle as W1C write 0x4 → EDGECAP bit 2 remains 1.
- IRQMASK=0, rising edge on bit 1 → EDGECAP=0x2, irq=0. Then write IRQMASK=0x2 → irq=1 one cycle later.
- SENSOR_PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - 10-cycle glitch on bit 3 → DATA and EDGECAP unchanged.
  - 20-cycle high on bit 3 → DATA bit 3=1 at 18 cycles after the change, EDGECAP=0x8.
- Assert reset_n low mid-debounce with EDGECAP=0xF → all registers 0, irq=0 immediately. No capture on release.
